// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the coordinate type for the raster scan generator.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/vga_scan_gen_if.sv
// Scan outputs of vga_scan_gen bundled for pixel consumers.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_scan_gen_if;
  import vga_timing_pkg::*;

  logic   pix_tick;
  coord_t visible_col;
  coord_t visible_row;
  logic   video_on;
  logic   hsync;
  logic   vsync;
  logic   frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    output pix_tick, visible_col, visible_row, video_on, hsync, vsync, frame_start
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input pix_tick, visible_col, visible_row, video_on, hsync, vsync, frame_start
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/pix_tick_div.sv
// Divides clk by PIX_DIV; tick_en is the combinational "tick on this edge" flag and
// pix_tick its registered copy, so counters clocked on tick_en move with pix_tick.
module pix_tick_div #(
  parameter int unsigned PIX_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_en,
  output logic pix_tick
);

  localparam int unsigned CW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(PIX_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  assign tick_en = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = tick_en ? '0 : div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      pix_tick  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_tick  <= tick_en;
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel tick, h/v counters, sync decode and visible coordinates.
// Define VGA_FRAME_CNT_EN to add a 16-bit frame counter output.
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned PIX_DIV  = 2,
  parameter bit          SYNC_POL = 1'b0
) (
  input logic            clk,
  input logic            BTN_S_n,
  vga_scan_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL >= 2 ** COORD_W || V_TOTAL >= 2 ** COORD_W) begin : g_bad_width
    $error("vga_scan_gen: timing totals must be below 2048");
  end
  if (PIX_DIV < 1) begin : g_bad_div
    $error("vga_scan_gen: PIX_DIV must be at least 1");
  end

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  logic   tick_en, pix_tick;
  coord_t h_q, h_d, v_q, v_d;
  coord_t col_q, col_d, row_q, row_d;
  logic   video_on_q, video_on_d;
  logic   hsync_q, hsync_d, vsync_q, vsync_d;
  logic   frame_start_q, frame_start_d;

  pix_tick_div #(
    .PIX_DIV(PIX_DIV)
  ) u_pix_tick_div (
    .clk     (clk),
    .rst_n   (BTN_S_n),
    .tick_en (tick_en),
    .pix_tick(pix_tick)
  );

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Decode from the next-state counters so every output lands on the counter edge.
  always_comb begin
    video_on_d    = (h_d < H_VIS) && (v_d < V_VIS);
    col_d         = video_on_d ? h_d : '0;
    row_d         = video_on_d ? v_d : '0;
    hsync_d       = ((h_d >= HS_START) && (h_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((v_d >= VS_START) && (v_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    frame_start_d = tick_en && (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge clk or negedge BTN_S_n) begin
    if (!BTN_S_n) begin
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      col_q         <= '0;
      row_q         <= '0;
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      col_q         <= col_d;
      row_q         <= row_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pix_tick    = pix_tick;
  assign vga.visible_col = col_q;
  assign vga.visible_row = row_q;
  assign vga.video_on    = video_on_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge BTN_S_n) begin
    if (!BTN_S_n) begin
      frame_cnt_q <= '0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule
